// File: rtl/warmboot_sequencer_pkg.sv
// Shared definitions for the warm-boot sequencer: FSM state encoding and
// image-select sizing.
package warmboot_sequencer_pkg;

    // Width of the {S1,S0} image select.
    localparam int IMG_W      = 2;
    // The warm-boot primitive addresses at most four images.
    localparam int MAX_IMAGES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_BOOT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/warmboot_sequencer_tick_prescaler.sv
// Free-running prescaler. While enabled it counts every clock and emits a
// one-cycle tick on the all-ones count, so the tick rate is one per
// 2^PRESCALE_W clocks. While disabled the count is frozen and no tick occurs.
module tick_prescaler
    import warmboot_sequencer_pkg::*;
#(
    parameter int PRESCALE_W = 22
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en_i,
    output logic tick_o
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    // Advance the count only while enabled; the all-ones count wraps to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + PRESCALE_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i & (&cnt_q);

endmodule

// File: rtl/warmboot_sequencer.sv
// Warm-boot sequencer: prescaled LED progress counter, selectable target
// image and a boot FSM driving the iCE40 warm-boot pins (BOOT, S1, S0).
// Define WARMBOOT_PRIM_EN to instantiate SB_WARMBOOT inside this block;
// otherwise boot/sel are only exported for the parent to consume.
module warmboot_sequencer
    import warmboot_sequencer_pkg::*;
#(
    parameter int PRESCALE_W     = 22,
    parameter int LED_W          = 5,
    parameter int NUM_IMAGES     = 4,
    parameter int NEXT_IMAGE_DEF = 1,
    parameter int AUTO_BOOT      = 1,
    parameter int SETUP_CYC      = 2,
    parameter int BOOT_HOLD      = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             boot_req,
    input  logic [IMG_W-1:0] image_req,
    input  logic             image_req_valid,
    output logic [LED_W-1:0] led,
    output logic [IMG_W-1:0] sel,
    output logic             boot,
    output logic             busy,
    output logic             req_err
);

    localparam int       HOLD_MAX  = (SETUP_CYC > BOOT_HOLD) ? SETUP_CYC : BOOT_HOLD;
    localparam int       CNT_W     = $clog2(HOLD_MAX + 1);
    localparam logic     AUTO_EN   = (AUTO_BOOT != 0);
    localparam logic [2:0] NUM_IMG_L = 3'(NUM_IMAGES);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [LED_W-1:0]   led_q;
    logic [LED_W-1:0]   led_d;
    logic [IMG_W-1:0]   sel_q;
    logic [IMG_W-1:0]   sel_d;
    logic               boot_q;
    logic               boot_d;
    logic               busy_q;
    logic               busy_d;
    logic               req_err_q;
    logic               req_err_d;
    logic               boot_req_q;

    logic               idle;
    logic               tick;
    logic               wrap;
    logic               rise;
    logic               trig;
    logic               img_ok;

    assign idle   = (state_q == ST_IDLE);
    assign rise   = boot_req & ~boot_req_q;
    assign wrap   = tick & (&led_q);
    assign trig   = idle & (rise | (AUTO_EN & wrap));
    assign img_ok = ({1'b0, image_req} < NUM_IMG_L);

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (idle),
        .tick_o  (tick)
    );

    // LED progress and image select; both are frozen outside IDLE.
    always_comb begin
        led_d     = led_q;
        sel_d     = sel_q;
        req_err_d = 1'b0;
        if (tick) begin
            led_d = led_q + LED_W'(1);
        end
        if (idle && image_req_valid) begin
            if (img_ok) begin
                sel_d = image_req;
            end else begin
                req_err_d = 1'b1;
            end
        end
    end

    // Datapath registers and the boot_req edge detector.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            led_q      <= '0;
            sel_q      <= IMG_W'(NEXT_IMAGE_DEF);
            req_err_q  <= 1'b0;
            boot_req_q <= 1'b0;
        end else begin
            led_q      <= led_d;
            sel_q      <= sel_d;
            req_err_q  <= req_err_d;
            boot_req_q <= boot_req;
        end
    end

    // FSM state register, phase counter and registered FSM outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            boot_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            boot_q  <= boot_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic. SETUP counts SETUP_CYC..0 so boot rises SETUP_CYC+1
    // edges after the trigger edge; BOOT counts BOOT_HOLD-1..0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC);
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_BOOT;
                    cnt_d   = CNT_W'(BOOT_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_BOOT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, registered in the state process.
    always_comb begin
        boot_d = (state_d == ST_BOOT) || (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    assign led     = led_q;
    assign sel     = sel_q;
    assign boot    = boot_q;
    assign busy    = busy_q;
    assign req_err = req_err_q;

`ifdef WARMBOOT_PRIM_EN
    SB_WARMBOOT u_warmboot (
        .BOOT (boot_q),
        .S1   (sel_q[1]),
        .S0   (sel_q[0])
    );
`else
    // No primitive: the parent consumes boot and sel directly.
`endif

endmodule
